nvme_cdc_bus: RTL and testbench
===============================

NVME_CDC_BUS -- requirements
Module: nvme_cdc_bus

Interface
REQ-001 SHALL have parameter width, default 32: bit width of the crossing data bus.
REQ-002 SHALL have parameter stages, default 3: synchronizer depth on the request toggle, legal range 2..8.
REQ-003 SHALL have port clk, input, 1: destination clock; all logic in this domain.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset in the clk domain.
REQ-005 SHALL have port src_req, input, 1: toggle from the source domain, asynchronous to clk; each change means new data on src_data.
REQ-006 SHALL have port src_data, input, width: source bus, held stable by the sender from the src_req toggle until src_ack matches.
REQ-007 SHALL have port src_ack, output, 1: acknowledge toggle to the source domain; equals src_req after a completed transfer.
REQ-008 SHALL have port q_valid, output, 1: captured word available.
REQ-009 SHALL have port q_ready, input, 1: consumer accepts q_data when high with q_valid.
REQ-010 SHALL have port q_data, output, width: captured word.
REQ-011 SHALL have port err, output, 1: sticky protocol-violation flag.

Function
REQ-012 SHALL pass src_req through a stages-deep flop chain to give req_sync; src_data SHALL NOT be synchronized per bit.
REQ-013 SHALL register req_last <= req_sync every cycle; edge = req_sync XOR req_last.
REQ-014 SHALL implement FSM IDLE / HOLD / ACK, reset state IDLE.
REQ-015 IDLE: on edge, SHALL capture src_data into q_data, set q_valid the next cycle, and go to HOLD.
REQ-016 HOLD: q_valid=1 and q_data stable; on q_valid&q_ready, SHALL clear q_valid the next cycle and go to ACK.
REQ-017 ACK: SHALL toggle src_ack for one cycle's transition and return to IDLE; src_ack is a registered output.
REQ-018 Latency: the first clk edge that samples a changed src_req, plus stages+1 cycles, gives q_valid=1 (back-to-back ready is not required).
REQ-019 Minimum transfer cycle in clk with q_ready tied high: q_valid high exactly 1 cycle; src_ack toggles 2 cycles after q_valid rises.
REQ-020 An edge seen in HOLD or ACK SHALL set err=1, SHALL be discarded, and SHALL NOT change q_data or the FSM.
REQ-021 Simultaneous edge and q_ready in HOLD: the transfer completes and err sets; the edge is not queued.
REQ-022 err SHALL stay set until reset.
REQ-023 q_ready while q_valid=0 SHALL have no effect.

Reset
REQ-024 reset SHALL force q_valid=0, q_data=0, err=0, FSM=IDLE in one cycle.
REQ-025 On reset, req_last and src_ack SHALL load the current req_sync value, so no spurious edge or ack follows reset.
REQ-026 The synchronizer flops SHALL NOT be reset.
REQ-027 A reset mid-HOLD SHALL drop the word without acking; src_ack equals req_sync, so the sender sees completion.

Structure
REQ-028 The synchronizer chain SHALL be an instance of the team single-bit synchronizer nvme_cdc with the stages parameter, and SHALL carry the ASYNC_REG attribute.
REQ-029 The FSM state encodings and the default stages constant SHALL live in the shared package nvme_cdc_pkg.
REQ-030 No other sub-modules.

Verification
REQ-031 Single transfer: with width=32 and stages=3, src_data=0xDEADBEEF and src_req 0->1 with q_ready=1 -> q_valid=1 for 1 cycle, 4 cycles after sampling, q_data=0xDEADBEEF, src_ack=1 two cycles later.
REQ-032 Backpressure: q_ready=0 for 10 cycles -> q_valid and q_data hold for 10 cycles, src_ack unchanged; ready=1 -> ack toggles 2 cycles later.
REQ-033 Back-to-back: 16 transfers of incrementing data, each sent after src_ack matches -> 16 words in order, err=0.
REQ-034 Violation: second src_req toggle during HOLD -> err=1 sticky, q_data unchanged, no extra q_valid.
REQ-035 Reset mid-HOLD with src_req=1 -> q_valid=0, src_ack=1 after reset, no q_valid within 20 cycles.
REQ-036 stages=2 and stages=8 sweeps -> latency is stages+1 in both cases.

Source files
------------

// File: rtl/nvme_cdc_pkg.sv
// nvme_cdc_pkg: shared FSM state encodings and default synchronizer depth for the CDC bus
package nvme_cdc_pkg;
  localparam int STAGES_DEFAULT = 3;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_ACK = 2'd2} state_e;
endpackage

// File: rtl/nvme_cdc.sv
// nvme_cdc: single-bit multi-flop synchronizer (clk, d_i async input, q_o synchronized output); flops are never reset
module nvme_cdc #(
  parameter int stages = 3
) (
  input  logic clk,
  input  logic d_i,
  output logic q_o
);
  (* ASYNC_REG = "TRUE" *) logic [stages-1:0] sync_q;
  always_ff @(posedge clk) sync_q <= {sync_q[stages-2:0], d_i};
  assign q_o = sync_q[stages-1];
endmodule

// File: rtl/nvme_cdc_bus.sv
// nvme_cdc_bus: toggle req/ack bus crossing into clk (src_req/src_data/src_ack from source, q_valid/q_ready/q_data to consumer, err sticky violation flag)
module nvme_cdc_bus
  import nvme_cdc_pkg::*;
#(
  parameter int width  = 32,
  parameter int stages = STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_req,
  input  logic [width-1:0] src_data,
  output logic             src_ack,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [width-1:0] q_data,
  output logic             err
);
  logic req_sync, req_last_q, req_edge, fire;
  logic q_valid_q, q_valid_d, ack_q, ack_d, err_q, err_d;
  logic [width-1:0] data_q, data_d;
  state_e state_q, state_d;
  nvme_cdc #(.stages(stages)) u_sync (.clk(clk), .d_i(src_req), .q_o(req_sync));
  assign req_edge = req_sync ^ req_last_q;
  assign fire = q_valid_q & q_ready;
  always_comb begin
    state_d   = state_q == S_IDLE && req_edge ? S_HOLD :
                state_q == S_HOLD && fire     ? S_ACK  :
                state_q == S_ACK              ? S_IDLE : state_q;
    data_d    = state_q == S_IDLE && req_edge ? src_data : data_q;
    // valid rises one cycle after capture and drops on the handshake
    q_valid_d = state_q == S_HOLD && !fire;
    ack_d     = ack_q ^ (state_q == S_ACK);
    // edges outside IDLE are dropped and only flagged
    err_d     = err_q | (req_edge && state_q != S_IDLE);
  end
  always_ff @(posedge clk) begin
    req_last_q <= req_sync;
    if (reset) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      q_valid_q <= 1'b0;
      err_q     <= 1'b0;
      // aligning ack with the synchronized request makes any dropped word look complete
      ack_q     <= req_sync;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      q_valid_q <= q_valid_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
    end
  end
  assign src_ack = ack_q;
  assign q_valid = q_valid_q;
  assign q_data  = data_q;
  assign err     = err_q;
endmodule

// File: tb/tb_nvme_cdc_bus.sv
// tb_nvme_cdc_bus: directed self-checking bench for nvme_cdc_bus (default, stages=2, stages=8)
module tb_nvme_cdc_bus;
  logic clk = 1'b0, reset = 1'b1, src_req = 1'b0, q_ready = 1'b0;
  logic [31:0] src_data = '0;
  logic src_ack, q_valid, err;
  logic [31:0] q_data;
  logic req2 = 1'b0, req8 = 1'b0, rdy_hi = 1'b1;
  logic ack2, v2, err2, ack8, v8, err8;
  logic [31:0] d2, d8;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  nvme_cdc_bus dut (.clk(clk), .reset(reset), .src_req(src_req), .src_data(src_data), .src_ack(src_ack),
    .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data), .err(err));
  nvme_cdc_bus #(.width(32), .stages(2)) dut2 (.clk(clk), .reset(reset), .src_req(req2), .src_data(src_data),
    .src_ack(ack2), .q_valid(v2), .q_ready(rdy_hi), .q_data(d2), .err(err2));
  nvme_cdc_bus #(.width(32), .stages(8)) dut8 (.clk(clk), .reset(reset), .src_req(req8), .src_data(src_data),
    .src_ack(ack8), .q_valid(v8), .q_ready(rdy_hi), .q_data(d8), .err(err8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    do begin tick(); lat++; end while (!q_valid && lat < 60);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    src_req = 1'b0;
    q_ready = 1'b1;
    repeat (12) tick();
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", q_valid); end
    checks++; if (q_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", q_data); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (src_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", src_ack); end
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (q_valid !== 1'b0 || src_ack !== 1'b0) begin failures++; $display("FAIL post_reset_idle valid=%b ack=%b exp=0/0", q_valid, src_ack); end
  endtask

  task automatic test_sweep();
    int l2 = -1, l8 = -1;
    src_data = 32'hCAFE0001;
    req2 = 1'b1;
    req8 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (v2 && l2 < 0) l2 = c;
      if (v8 && l8 < 0) l8 = c;
    end
    checks++; if (l2 !== 3) begin failures++; $display("FAIL latency_stages2 got=%0d exp=3", l2); end
    checks++; if (l8 !== 9) begin failures++; $display("FAIL latency_stages8 got=%0d exp=9", l8); end
    checks++; if (d2 !== 32'hCAFE0001 || d8 !== 32'hCAFE0001) begin failures++; $display("FAIL sweep_data got=%h/%h exp=cafe0001", d2, d8); end
    checks++; if (ack2 !== 1'b1 || ack8 !== 1'b1) begin failures++; $display("FAIL sweep_ack got=%b/%b exp=1/1", ack2, ack8); end
  endtask

  task automatic test_single();
    int lat;
    src_data = 32'hDEADBEEF;
    q_ready = 1'b1;
    src_req = 1'b1;
    wait_valid(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", lat); end
    checks++; if (q_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", q_data); end
    checks++; if (src_ack !== 1'b0) begin failures++; $display("FAIL single_ack_early got=%b exp=0", src_ack); end
    tick();
    checks++; if (q_valid !== 1'b0 || src_ack !== 1'b0) begin failures++; $display("FAIL single_one_cycle valid=%b ack=%b exp=0/0", q_valid, src_ack); end
    tick();
    checks++; if (src_ack !== 1'b1) begin failures++; $display("FAIL single_ack got=%b exp=1", src_ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
  endtask

  task automatic test_backpressure();
    int lat;
    q_ready = 1'b0;
    src_data = 32'h12345678;
    src_req = 1'b0;
    wait_valid(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (q_valid !== 1'b1 || q_data !== 32'h12345678 || src_ack !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid=%b data=%h ack=%b exp=1/12345678/1", i, q_valid, q_data, src_ack);
      end
    end
    q_ready = 1'b1;
    tick();
    checks++; if (q_valid !== 1'b0 || src_ack !== 1'b1) begin failures++; $display("FAIL bp_release valid=%b ack=%b exp=0/1", q_valid, src_ack); end
    tick();
    checks++; if (src_ack !== 1'b0) begin failures++; $display("FAIL bp_ack got=%b exp=0", src_ack); end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    q_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      src_data = 32'h100 + i;
      src_req = ~src_req;
      wait_valid(lat);
      checks++;
      if (q_valid !== 1'b1 || q_data !== 32'h100 + i) begin
        failures++;
        $display("FAIL b2b_word idx=%0d valid=%b data=%h exp=1/%h", i, q_valid, q_data, 32'h100 + i);
      end
      n = 0;
      while (src_ack !== src_req && n < 20) begin tick(); n++; end
      checks++; if (src_ack !== src_req) begin failures++; $display("FAIL b2b_ack idx=%0d ack=%b exp=%b", i, src_ack, src_req); end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", err); end
  endtask

  task automatic test_violation();
    int lat, extra = 0;
    q_ready = 1'b0;
    src_data = 32'hA5A5A5A5;
    src_req = ~src_req;
    wait_valid(lat);
    checks++; if (q_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL viol_first got=%h exp=a5a5a5a5", q_data); end
    src_data = 32'hFFFF0000;
    src_req = ~src_req;
    repeat (10) tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL viol_err got=%b exp=1", err); end
    checks++; if (q_data !== 32'hA5A5A5A5 || q_valid !== 1'b1) begin failures++; $display("FAIL viol_hold data=%h valid=%b exp=a5a5a5a5/1", q_data, q_valid); end
    q_ready = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin tick(); if (q_valid) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL viol_extra_valid got=%0d exp=0", extra); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL viol_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid_hold();
    int lat, extra = 0, bad_ack = 0;
    reset = 1'b1;
    src_req = 1'b0;
    q_ready = 1'b0;
    repeat (6) tick();
    reset = 1'b0;
    checks++; if (err !== 1'b0 || src_ack !== 1'b0) begin failures++; $display("FAIL rmh_pre err=%b ack=%b exp=0/0", err, src_ack); end
    src_data = 32'h0BADF00D;
    src_req = 1'b1;
    wait_valid(lat);
    checks++; if (q_valid !== 1'b1 || q_data !== 32'h0BADF00D) begin failures++; $display("FAIL rmh_hold valid=%b data=%h exp=1/0badf00d", q_valid, q_data); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (q_valid !== 1'b0 || q_data !== 32'h0 || src_ack !== 1'b1) begin failures++; $display("FAIL rmh_reset valid=%b data=%h ack=%b exp=0/0/1", q_valid, q_data, src_ack); end
    q_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); if (q_valid) extra++; if (src_ack !== 1'b1) bad_ack++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL rmh_no_valid got=%0d exp=0", extra); end
    checks++; if (bad_ack !== 0) begin failures++; $display("FAIL rmh_ack_stable got=%0d exp=0", bad_ack); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_violation();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
